// File: rtl/ctx_pkg.sv
// Shared types for the context dispatcher: FSM states, table entry layout and
// the default OS re-entry address.
package ctx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        RUN   = 2'd2,
        LEAVE = 2'd3
    } ctx_state_e;

    localparam logic [31:0] OS_VECTOR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } ctx_entry_t;

endpackage

// File: rtl/ctx_table.sv
// Process table register file: one write port, two asynchronous read ports.
// Reads return the stored value; a write in the same cycle is not forwarded.
module ctx_table
    import ctx_pkg::*;
#(
    parameter int NPROC = 4,
    parameter int PID_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [PID_W-1:0] wpid,
    input  ctx_entry_t       wdata,
    input  logic [PID_W-1:0] rpid_a,
    output ctx_entry_t       rdata_a,
    input  logic [PID_W-1:0] rpid_b,
    output ctx_entry_t       rdata_b
);

    ctx_entry_t table_q [NPROC];
    ctx_entry_t table_d [NPROC];

    always_comb begin
        table_d = table_q;
        if (we) begin
            table_d[wpid] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    assign rdata_a = table_q[rpid_a];
    assign rdata_b = table_q[rpid_b];

endmodule

// File: rtl/context_dispatcher.sv
// Time-slice dispatcher: enters a process from the OS, counts retired
// instructions, and returns to the OS vector on quantum expiry or exit.
module context_dispatcher
    import ctx_pkg::*;
#(
    parameter int          NPROC     = 4,
    parameter int          PID_W     = 2,
    parameter int          QUANTUM   = 10,
    parameter logic [31:0] OS_VECTOR = OS_VECTOR_DEFAULT
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             set_we,
    input  logic [PID_W-1:0] set_pid,
    input  logic [31:0]      set_pc,
    input  logic             dispatch_req,
    input  logic [PID_W-1:0] dispatch_pid,
    output logic             dispatch_ack,
    output logic             dispatch_err,
    input  logic             retire,
    input  logic [31:0]      retire_pc,
    input  logic             prog_exit,
    output logic             jump,
    output logic [31:0]      jump_target,
    output logic             inProgram,
    output logic [PID_W-1:0] current_pid,
    output logic             busy
);

    localparam logic [7:0] LAST_COUNT = 8'(QUANTUM - 1);

    ctx_state_e       state_q, state_d;
    logic [PID_W-1:0] pid_q, pid_d;
    logic [7:0]       count_q, count_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             jump_q, jump_d;
    logic [31:0]      target_q, target_d;
    logic             in_program_q, in_program_d;

    logic             save_we;
    ctx_entry_t       save_entry;
    logic             tbl_we;
    logic [PID_W-1:0] tbl_wpid;
    ctx_entry_t       tbl_wdata;
    ctx_entry_t       disp_entry;
    ctx_entry_t       run_entry;

    ctx_table #(
        .NPROC (NPROC),
        .PID_W (PID_W)
    ) u_table (
        .clk     (CLK),
        .reset   (reset),
        .we      (tbl_we),
        .wpid    (tbl_wpid),
        .wdata   (tbl_wdata),
        .rpid_a  (dispatch_pid),
        .rdata_a (disp_entry),
        .rpid_b  (pid_q),
        .rdata_b (run_entry)
    );

    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        count_d      = count_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        jump_d       = 1'b0;
        target_d     = target_q;
        // inProgram rises one edge after the jump into the process and falls
        // one edge after the jump back to the OS.
        in_program_d = (state_q == RUN) || (state_q == LEAVE);
        save_we      = 1'b0;
        save_entry   = '0;
        case (state_q)
            IDLE: begin
                if (dispatch_req) begin
                    if (disp_entry.valid) begin
                        pid_d   = dispatch_pid;
                        ack_d   = 1'b1;
                        state_d = ENTER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ENTER: begin
                jump_d   = 1'b1;
                target_d = run_entry.pc;
                count_d  = 8'd0;
                state_d  = RUN;
            end
            RUN: begin
                if (prog_exit) begin
                    save_we    = 1'b1;
                    save_entry = '{valid: 1'b0, pc: run_entry.pc};
                    state_d    = LEAVE;
                end else if (retire) begin
                    if (count_q == LAST_COUNT) begin
                        save_we    = 1'b1;
                        save_entry = '{valid: 1'b1, pc: retire_pc + 32'd4};
                        state_d    = LEAVE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            LEAVE: begin
                jump_d   = 1'b1;
                target_d = OS_VECTOR;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Context saves own the write port; OS writes to the running pid are dropped.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_wpid  = set_pid;
        tbl_wdata = '{valid: 1'b1, pc: {set_pc[31:2], 2'b00}};
        if (save_we) begin
            tbl_we    = 1'b1;
            tbl_wpid  = pid_q;
            tbl_wdata = save_entry;
        end else if (set_we && !(state_q == RUN && set_pid == pid_q)) begin
            tbl_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            pid_q        <= '0;
            count_q      <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            jump_q       <= 1'b0;
            target_q     <= '0;
            in_program_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pid_q        <= pid_d;
            count_q      <= count_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            jump_q       <= jump_d;
            target_q     <= target_d;
            in_program_q <= in_program_d;
        end
    end

    assign dispatch_ack = ack_q;
    assign dispatch_err = err_q;
    assign jump         = jump_q;
    assign jump_target  = target_q;
    assign inProgram    = in_program_q;
    assign current_pid  = pid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_context_dispatcher.sv
// Directed bench for context_dispatcher: dispatch, quantum expiry, exit,
// wrap, ignored requests and reset during a running process.
module tb_context_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_we;
    logic [1:0]  set_pid;
    logic [31:0] set_pc;
    logic        dispatch_req;
    logic [1:0]  dispatch_pid;
    logic        dispatch_ack;
    logic        dispatch_err;
    logic        retire;
    logic [31:0] retire_pc;
    logic        prog_exit;
    logic        jump;
    logic [31:0] jump_target;
    logic        inProgram;
    logic [1:0]  current_pid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    context_dispatcher #(
        .NPROC     (4),
        .PID_W     (2),
        .QUANTUM   (10),
        .OS_VECTOR (32'h0000_0000)
    ) dut (
        .CLK          (clk),
        .reset        (reset),
        .set_we       (set_we),
        .set_pid      (set_pid),
        .set_pc       (set_pc),
        .dispatch_req (dispatch_req),
        .dispatch_pid (dispatch_pid),
        .dispatch_ack (dispatch_ack),
        .dispatch_err (dispatch_err),
        .retire       (retire),
        .retire_pc    (retire_pc),
        .prog_exit    (prog_exit),
        .jump         (jump),
        .jump_target  (jump_target),
        .inProgram    (inProgram),
        .current_pid  (current_pid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Inputs set before a step are sampled at its edge; outputs are read 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dispatch(input logic [1:0] pid);
        dispatch_req = 1'b1;
        dispatch_pid = pid;
        step();
        dispatch_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; set_we = 1'b0; set_pid = '0; set_pc = '0;
        dispatch_req = 1'b0; dispatch_pid = '0;
        retire = 1'b0; retire_pc = '0; prog_exit = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_jump", jump, 0);
        check("rst_target", jump_target, 0);
        check("rst_inprog", inProgram, 0);
        check("rst_pid", current_pid, 0);
        check("rst_ack", dispatch_ack, 0);
        check("rst_err", dispatch_err, 0);
        check("rst_busy", busy, 0);

        // Basic dispatch of pid1; low pc bits are dropped on write.
        set_we = 1'b1; set_pid = 2'd1; set_pc = 32'h0000_0103;
        step();
        set_we = 1'b0;
        dispatch(2'd1);
        check("d1_ack", dispatch_ack, 1);
        check("d1_busy", busy, 1);
        check("d1_jump_early", jump, 0);
        step();
        check("d1_jump", jump, 1);
        check("d1_target", jump_target, 32'h100);
        check("d1_ack_pulse", dispatch_ack, 0);
        check("d1_inprog_early", inProgram, 0);
        step();
        check("d1_inprog", inProgram, 1);
        check("d1_jump_pulse", jump, 0);
        check("d1_pid", current_pid, 1);

        // Requests in RUN are ignored; a write to another pid still lands.
        set_we = 1'b1; set_pid = 2'd0; set_pc = 32'h0000_0700;
        dispatch_req = 1'b1; dispatch_pid = 2'd2;
        step();
        check("ign_err", dispatch_err, 0);
        check("ign_ack0", dispatch_ack, 0);
        set_pid = 2'd1; set_pc = 32'h0000_0200;
        dispatch_pid = 2'd0;
        step();
        set_we = 1'b0; dispatch_req = 1'b0;
        check("ign_ack1", dispatch_ack, 0);
        check("ign_err1", dispatch_err, 0);
        check("ign_inprog", inProgram, 1);

        // Quantum expiry: ten retires, last at 0x124.
        for (int i = 0; i < 10; i++) begin
            retire = 1'b1;
            retire_pc = 32'h100 + 32'(4 * i);
            step();
        end
        retire = 1'b0;
        check("q_jump_early", jump, 0);
        check("q_inprog_hold", inProgram, 1);
        step();
        check("q_jump", jump, 1);
        check("q_target", jump_target, 32'h0);
        check("q_inprog_m2", inProgram, 1);
        step();
        check("q_inprog_low", inProgram, 0);
        check("q_busy", busy, 0);

        // Redispatch resumes at the saved pc.
        dispatch(2'd1);
        check("rd_ack", dispatch_ack, 1);
        step();
        check("rd_jump", jump, 1);
        check("rd_target", jump_target, 32'h128);
        step();
        check("rd_inprog", inProgram, 1);

        // Exit after three retires; exit wins over a same-cycle retire.
        for (int i = 0; i < 3; i++) begin
            retire = 1'b1;
            retire_pc = 32'h128 + 32'(4 * i);
            step();
        end
        prog_exit = 1'b1;
        step();
        prog_exit = 1'b0; retire = 1'b0;
        step();
        check("ex_jump", jump, 1);
        check("ex_target", jump_target, 32'h0);
        step();
        check("ex_inprog", inProgram, 0);
        dispatch(2'd1);
        check("ex_err", dispatch_err, 1);
        check("ex_ack", dispatch_ack, 0);
        step();
        check("ex_nojump", jump, 0);
        check("ex_err_pulse", dispatch_err, 0);
        check("ex_busy", busy, 0);

        // pid0 was written during RUN; run it to a wrapping quantum end.
        dispatch(2'd0);
        check("w_ack", dispatch_ack, 1);
        step();
        check("w_target_in", jump_target, 32'h700);
        step();
        check("w_pid", current_pid, 0);
        for (int i = 0; i < 10; i++) begin
            retire = 1'b1;
            retire_pc = 32'hFFFF_FFD8 + 32'(4 * i);
            step();
        end
        retire = 1'b0;
        step();
        check("w_jump_os", jump, 1);
        step();
        dispatch(2'd0);
        check("w_ack2", dispatch_ack, 1);
        step();
        check("w_jump2", jump, 1);
        check("w_target_wrap", jump_target, 32'h0);
        step();

        // pid0 in RUN now; let it exit so the bench returns to IDLE.
        prog_exit = 1'b1;
        step();
        prog_exit = 1'b0;
        step();
        step();
        check("w_idle", busy, 0);

        // Same-cycle write and dispatch to pid2: dispatch sees old valid.
        set_we = 1'b1; set_pid = 2'd2; set_pc = 32'h0000_0080;
        dispatch(2'd2);
        set_we = 1'b0;
        check("sim_err", dispatch_err, 1);
        check("sim_ack", dispatch_ack, 0);
        dispatch(2'd2);
        check("sim_ack2", dispatch_ack, 1);
        step();
        check("sim_target", jump_target, 32'h80);
        step();
        check("sim_pid", current_pid, 2);

        // Reset after five retires.
        for (int i = 0; i < 5; i++) begin
            retire = 1'b1;
            retire_pc = 32'h80 + 32'(4 * i);
            step();
        end
        retire = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_inprog", inProgram, 0);
        check("mr_jump", jump, 0);
        check("mr_busy", busy, 0);
        check("mr_pid", current_pid, 0);
        check("mr_target", jump_target, 0);
        dispatch(2'd2);
        check("mr_err2", dispatch_err, 1);
        dispatch(2'd1);
        check("mr_err1", dispatch_err, 1);
        check("mr_ack", dispatch_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
